// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared state encoding and stage-control bundle for the sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } seqState_t;

  localparam int STAGE_CTL_W = 7;

  typedef struct packed {
    logic pcWrite;
    logic ifIdWrite;
    logic ifIdFlush;
    logic idExBubble;
    logic idExWrite;
    logic exMemWrite;
    logic memWbWrite;
  } stageCtl_t;

  function automatic stageCtl_t ctlFreeze();
    return '0;
  endfunction

  // Branch redirect beats load-use: the stalled instruction is on the wrong path.
  function automatic stageCtl_t ctlRun(input logic branchTaken, input logic loadUse);
    stageCtl_t c;
    c = '{pcWrite: 1'b1, ifIdWrite: 1'b1, ifIdFlush: 1'b0, idExBubble: 1'b0,
          idExWrite: 1'b1, exMemWrite: 1'b1, memWbWrite: 1'b1};
    if (branchTaken) begin
      c.ifIdFlush  = 1'b1;
      c.idExBubble = 1'b1;
    end else if (loadUse) begin
      c.pcWrite    = 1'b0;
      c.ifIdWrite  = 1'b0;
      c.idExBubble = 1'b1;
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_control_sequencer_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : W-bit up-counter that sticks at all-ones; async reset, sync clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign q = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_control_sequencer.sv
// ============================================================================
// Module   : pipeline_control_sequencer
// Brief    : Stall/flush sequencer merging load-use, branch, memory-wait and halt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_control_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  seqState_t   r_state;
  seqState_t   w_nextState;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [WAIT_W-1:0] w_nextWaitCnt;
  logic        r_memErr;
  logic        w_setErr;
  logic        w_limitHit;
  logic        w_stallInc;
  stageCtl_t   w_ctl;
  stageCtl_t   w_ctlOut;

  // Counting in int keeps wait_cnt+1 from wrapping when WAIT_W is tight.
  assign w_limitHit = (int'(r_waitCnt) + 1) >= MEM_TIMEOUT;

  always_comb begin
    w_ctl         = ctlFreeze();
    w_nextState   = r_state;
    w_nextWaitCnt = r_waitCnt;
    w_setErr      = 1'b0;
    case (r_state)
      RUN: begin
        if (halt_req) begin
          w_nextState = HALT;
        end else if (mem_req && !mem_ready) begin
          w_nextState   = MEM_WAIT;
          w_nextWaitCnt = WAIT_W'(1);
        end else begin
          w_ctl = ctlRun(branch_taken, load_use);
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          w_ctl         = ctlRun(branch_taken, load_use);
          w_nextState   = RUN;
          w_nextWaitCnt = '0;
        end else if (w_limitHit) begin
          w_setErr    = 1'b1;
          w_nextState = HALT;
        end else begin
          w_nextWaitCnt = r_waitCnt + 1'b1;
        end
      end
      HALT: begin
        w_nextState = HALT;
      end
      default: begin
        w_nextState   = RUN;
        w_nextWaitCnt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RUN;
      r_waitCnt <= '0;
      r_memErr  <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
      if (w_setErr) begin
        r_memErr <= 1'b1;
      end
    end
  end

  // State resets to RUN asynchronously, so the Mealy enables must be masked by rst.
  assign w_ctlOut   = rst ? ctlFreeze() : w_ctl;
  assign w_stallInc = !w_ctlOut.pcWrite && (r_state != HALT) && !rst;

  sat_counter #(
    .W (CNT_W)
  ) u_stallCnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stallInc),
    .clr (1'b0),
    .q   (stall_cycles)
  );

  assign pc_write     = w_ctlOut.pcWrite;
  assign if_id_write  = w_ctlOut.ifIdWrite;
  assign if_id_flush  = w_ctlOut.ifIdFlush;
  assign id_ex_bubble = w_ctlOut.idExBubble;
  assign id_ex_write  = w_ctlOut.idExWrite;
  assign ex_mem_write = w_ctlOut.exMemWrite;
  assign mem_wb_write = w_ctlOut.memWbWrite;
  assign halted       = (r_state == HALT);
  assign mem_err      = r_memErr;

endmodule

`default_nettype wire
